// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: bus widths, EX/MEM and MEM/WB field
// offsets, control-bit indices and FSM state encodings.
package mem_access_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int REG_WR_SIZE = 5;

    localparam int EXM_W       = 2*WORD_SIZE + 2 + WORD_SIZE + REG_WR_SIZE;
    localparam int EXM_WR_LSB  = 0;
    localparam int EXM_RD2_LSB = EXM_WR_LSB + REG_WR_SIZE;
    localparam int EXM_ALU_LSB = EXM_RD2_LSB + WORD_SIZE;
    localparam int EXM_BFLAG   = EXM_ALU_LSB + WORD_SIZE;
    localparam int EXM_ZFLAG   = EXM_BFLAG + 1;
    localparam int EXM_TGT_LSB = EXM_ZFLAG + 1;

    localparam int MWB_W       = 2*WORD_SIZE + REG_WR_SIZE;

    localparam int M_BRANCH    = 2;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;
    localparam int WB_REG_WR   = 1;
    localparam int WB_MEM2REG  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_req_timer.sv
// Cycle counter for an outstanding data-memory access; expired_o flags the
// last allowed WAIT cycle.
module mem_req_timer
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    assign expired_o = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: branch resolution, word load/store over a req/ack port
// with timeout, upstream stall and registered MEM/WB bus.
//   state | meaning
//   IDLE  | no access outstanding; bus processed in one cycle
//   WAIT  | request held on the data-memory port until ack or timeout
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [EXM_W-1:0]     i_ex_mem_reg,
    input  logic                 i_valid,
    input  logic [2:0]           i_m,
    input  logic [1:0]           i_wb,
    output logic                 o_stall,
    output logic                 o_pc_src,
    output logic [WORD_SIZE-1:0] o_branch_target,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [WORD_SIZE-1:0] o_dmem_addr,
    output logic [WORD_SIZE-1:0] o_dmem_wdata,
    input  logic                 i_dmem_ack,
    input  logic [WORD_SIZE-1:0] i_dmem_rdata,
    output logic [MWB_W-1:0]     o_mem_wb_reg,
    output logic [1:0]           o_wb,
    output logic                 o_wb_valid,
    output logic                 o_fault
);

    mem_state_e             state_q, state_d;
    logic                   req_q, req_d, we_q, we_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [REG_WR_SIZE-1:0] wr_reg_q, wr_reg_d;
    logic [1:0]             wb_lat_q, wb_lat_d, wb_q, wb_d;
    logic [MWB_W-1:0]       mem_wb_q, mem_wb_d;
    logic                   wb_valid_q, wb_valid_d, fault_q, fault_d;
    logic                   done_q, done_d;
    logic                   tmr_clr, tmr_en, tmr_expired;

    logic [WORD_SIZE-1:0]   alu_result, rd2;
    logic [REG_WR_SIZE-1:0] wr_reg;
    logic                   branch_flag, memop, aligned, unused_zero_flag;

    assign alu_result       = i_ex_mem_reg[EXM_ALU_LSB +: WORD_SIZE];
    assign rd2              = i_ex_mem_reg[EXM_RD2_LSB +: WORD_SIZE];
    assign wr_reg           = i_ex_mem_reg[EXM_WR_LSB +: REG_WR_SIZE];
    assign branch_flag      = i_ex_mem_reg[EXM_BFLAG];
    assign unused_zero_flag = i_ex_mem_reg[EXM_ZFLAG];
    assign o_branch_target  = i_ex_mem_reg[EXM_TGT_LSB +: WORD_SIZE];

    assign memop   = i_valid & (i_m[M_READ] | i_m[M_WRITE]);
    assign aligned = (alu_result[1:0] == 2'b00);

    // done_q marks the cycle after completion: the bus still shows the retired
    // access while upstream advances, so it must not be issued again.
    assign o_stall  = ((state_q == ST_IDLE) & memop & aligned & ~done_q) | (state_q == ST_WAIT);
    assign o_pc_src = i_valid & i_m[M_BRANCH] & branch_flag & (state_q != ST_WAIT);

    mem_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_timer (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_reg_q   <= '0;
            wb_lat_q   <= '0;
            mem_wb_q   <= '0;
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_reg_q   <= wr_reg_d;
            wb_lat_q   <= wb_lat_d;
            mem_wb_q   <= mem_wb_d;
            wb_q       <= wb_d;
            wb_valid_q <= wb_valid_d;
            fault_q    <= fault_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_reg_d   = wr_reg_q;
        wb_lat_d   = wb_lat_q;
        mem_wb_d   = mem_wb_q;
        wb_d       = wb_q;
        wb_valid_d = 1'b0;
        fault_d    = 1'b0;
        done_d     = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && !done_q) begin
                    if (memop && aligned) begin
                        req_d    = 1'b1;
                        we_d     = i_m[M_WRITE];
                        addr_d   = alu_result;
                        wdata_d  = rd2;
                        wr_reg_d = wr_reg;
                        wb_lat_d = i_wb;
                        tmr_clr  = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        mem_wb_d   = {{WORD_SIZE{1'b0}}, alu_result, wr_reg};
                        wb_d       = memop ? {1'b0, i_wb[WB_MEM2REG]} : i_wb;
                        wb_valid_d = 1'b1;
                        fault_d    = memop;
                    end
                end
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (i_dmem_ack) begin
                    mem_wb_d   = {(we_q ? {WORD_SIZE{1'b0}} : i_dmem_rdata), addr_q, wr_reg_q};
                    wb_d       = wb_lat_q;
                    wb_valid_d = 1'b1;
                    req_d      = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else if (tmr_expired) begin
                    mem_wb_d   = {{WORD_SIZE{1'b0}}, addr_q, wr_reg_q};
                    wb_d       = {1'b0, wb_lat_q[WB_MEM2REG]};
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    req_d      = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_mem_wb_reg = mem_wb_q;
    assign o_wb         = wb_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_fault      = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for the MEM stage: ALU pass-through, load/store
// handshakes, misalignment, timeout, branch and asynchronous reset.
module tb_mem_access;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [102:0]  i_ex_mem_reg;
    logic          i_valid;
    logic [2:0]    i_m;
    logic [1:0]    i_wb;
    logic          o_stall, o_pc_src, o_dmem_req, o_dmem_we, i_dmem_ack;
    logic [31:0]   o_branch_target, o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
    logic [68:0]   o_mem_wb_reg;
    logic [1:0]    o_wb;
    logic          o_wb_valid, o_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    mem_access dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ex_mem_reg(i_ex_mem_reg), .i_valid(i_valid),
        .i_m(i_m), .i_wb(i_wb), .o_stall(o_stall), .o_pc_src(o_pc_src),
        .o_branch_target(o_branch_target), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_mem_wb_reg(o_mem_wb_reg), .o_wb(o_wb),
        .o_wb_valid(o_wb_valid), .o_fault(o_fault)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [102:0] bus(input logic [31:0] tgt, input logic bf,
                                         input logic [31:0] alu, input logic [31:0] rd2,
                                         input logic [4:0] wr);
        return {tgt, 1'b0, bf, alu, rd2, wr};
    endfunction

    task automatic drive(input logic [102:0] b, input logic [2:0] m, input logic [1:0] wb);
        i_ex_mem_reg = b;
        i_m          = m;
        i_wb         = wb;
        i_valid      = 1'b1;
    endtask

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_m = '0; i_wb = '0; i_ex_mem_reg = '0;
        i_dmem_ack = 1'b0; i_dmem_rdata = '0;
        #12;
        chk("rst_req",      o_dmem_req,   1'b0);
        chk("rst_wbv",      o_wb_valid,   1'b0);
        chk("rst_mwb",      o_mem_wb_reg, 69'd0);
        chk("rst_wb",       o_wb,         2'b00);
        chk("rst_fault",    o_fault,      1'b0);
        chk("rst_addr",     o_dmem_addr,  32'd0);
        @(negedge i_clk); i_rst = 1'b1;

        // ALU op
        @(negedge i_clk);
        drive(bus(32'h0, 1'b0, 32'h40, 32'h0, 5'd7), 3'b000, 2'b10);
        #1 chk("alu_stall", o_stall, 1'b0);
        @(negedge i_clk);
        chk("alu_wbv",   o_wb_valid,   1'b1);
        chk("alu_mwb",   o_mem_wb_reg, {32'h0, 32'h40, 5'd7});
        chk("alu_wb",    o_wb,         2'b10);
        chk("alu_fault", o_fault,      1'b0);
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("idle_wbv", o_wb_valid, 1'b0);

        // Load from 0x100, ack on 4th WAIT cycle
        drive(bus(32'h0, 1'b0, 32'h100, 32'h0, 5'd3), 3'b010, 2'b11);
        i_dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("ld_stall0", o_stall, 1'b1);
        chk("ld_req0", o_dmem_req, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("ld_req",   o_dmem_req,  1'b1);
            chk("ld_addr",  o_dmem_addr, 32'h100);
            chk("ld_we",    o_dmem_we,   1'b0);
            chk("ld_stall", o_stall,     1'b1);
            chk("ld_wbv_wait", o_wb_valid, 1'b0);
            i_dmem_ack = (k == 3);
        end
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        chk("ld_req_off", o_dmem_req,   1'b0);
        chk("ld_wbv",     o_wb_valid,   1'b1);
        chk("ld_mwb",     o_mem_wb_reg, {32'hDEAD_BEEF, 32'h100, 5'd3});
        chk("ld_wb",      o_wb,         2'b11);
        chk("ld_stall_after", o_stall,  1'b0);
        @(negedge i_clk);
        chk("ld_no_reissue", o_dmem_req, 1'b0);
        chk("ld_wbv_once",   o_wb_valid, 1'b0);
        i_valid = 1'b0;

        // Store of 0x12345678 to 0x8, immediate ack
        @(negedge i_clk);
        drive(bus(32'h0, 1'b0, 32'h8, 32'h1234_5678, 5'd0), 3'b001, 2'b00);
        i_dmem_rdata = 32'hFFFF_FFFF;
        #1 chk("st_stall0", o_stall, 1'b1);
        @(negedge i_clk);
        chk("st_req",   o_dmem_req,   1'b1);
        chk("st_we",    o_dmem_we,    1'b1);
        chk("st_wdata", o_dmem_wdata, 32'h1234_5678);
        chk("st_addr",  o_dmem_addr,  32'h8);
        chk("st_stall", o_stall,      1'b1);
        i_dmem_ack = 1'b1;
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        chk("st_wbv",   o_wb_valid,   1'b1);
        chk("st_mwb",   o_mem_wb_reg, {32'h0, 32'h8, 5'd0});
        chk("st_req_off", o_dmem_req, 1'b0);
        chk("st_stall_after", o_stall, 1'b0);
        i_valid = 1'b0;

        // Misaligned load from 0x102
        @(negedge i_clk);
        drive(bus(32'h0, 1'b0, 32'h102, 32'h0, 5'd9), 3'b010, 2'b11);
        #1 chk("mis_stall", o_stall, 1'b0);
        @(negedge i_clk);
        chk("mis_req",   o_dmem_req,   1'b0);
        chk("mis_fault", o_fault,      1'b1);
        chk("mis_wbv",   o_wb_valid,   1'b1);
        chk("mis_wb",    o_wb,         2'b01);
        chk("mis_mwb",   o_mem_wb_reg, {32'h0, 32'h102, 5'd9});
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("mis_fault_pulse", o_fault, 1'b0);

        // Load with no ack: timeout after 16 WAIT cycles
        drive(bus(32'h0, 1'b0, 32'h200, 32'h0, 5'd4), 3'b010, 2'b11);
        for (int k = 0; k < 16; k++) begin
            @(negedge i_clk);
            chk("to_req", o_dmem_req, 1'b1);
            chk("to_fault_wait", o_fault, 1'b0);
        end
        @(negedge i_clk);
        chk("to_req_off", o_dmem_req,   1'b0);
        chk("to_fault",   o_fault,      1'b1);
        chk("to_wbv",     o_wb_valid,   1'b1);
        chk("to_wb",      o_wb,         2'b01);
        chk("to_mwb",     o_mem_wb_reg, {32'h0, 32'h200, 5'd4});
        chk("to_stall",   o_stall,      1'b0);
        i_valid = 1'b0; i_dmem_ack = 1'b1;
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        chk("late_ack_wbv",   o_wb_valid, 1'b0);
        chk("late_ack_fault", o_fault,    1'b0);
        chk("late_ack_req",   o_dmem_req, 1'b0);

        // Branch
        drive(bus(32'h200, 1'b1, 32'h0, 32'h0, 5'd0), 3'b100, 2'b00);
        #1 chk("br_pcsrc", o_pc_src,        1'b1);
        chk("br_target",   o_branch_target, 32'h200);
        chk("br_stall",    o_stall,         1'b0);
        i_ex_mem_reg = bus(32'h200, 1'b0, 32'h0, 32'h0, 5'd0);
        #1 chk("br_not_taken", o_pc_src, 1'b0);
        i_valid = 1'b0;

        // Reset during WAIT
        @(negedge i_clk);
        drive(bus(32'h0, 1'b0, 32'h300, 32'h0, 5'd5), 3'b010, 2'b11);
        @(negedge i_clk);
        chk("rw_req", o_dmem_req, 1'b1);
        #2 i_rst = 1'b0;
        #1;
        chk("rw_req_off", o_dmem_req,   1'b0);
        chk("rw_mwb",     o_mem_wb_reg, 69'd0);
        chk("rw_wb",      o_wb,         2'b00);
        chk("rw_addr",    o_dmem_addr,  32'd0);
        chk("rw_stall",   o_stall,      1'b1);
        @(negedge i_clk);
        i_valid = 1'b0; i_dmem_ack = 1'b1; i_rst = 1'b1;
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        chk("rw_late_wbv", o_wb_valid, 1'b0);
        chk("rw_late_req", o_dmem_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
